// File: rtl/conv_pkg.sv
// Shared types and sizing helpers for the convolution output path.
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DRAIN
  } state_t;

  function automatic int unsigned k_bits(input int unsigned maxk);
    return $clog2(maxk + 1);
  endfunction

  function automatic int unsigned cnt_bits(input int unsigned r, input int unsigned c);
    return $clog2(r * c + 1);
  endfunction

  // Number of valid output positions for a KxK window over an RxC matrix.
  function automatic int unsigned out_total(input int unsigned r, input int unsigned c,
                                            input int unsigned k);
    return (r - k + 1) * (c - k + 1);
  endfunction

endpackage

// File: rtl/output_fifo.sv
// Result-word FIFO: uncleared storage, reset pointers, occupancy count for full/empty.
module output_fifo #(
  parameter int unsigned OUTW  = 56,
  parameter int unsigned DEPTH = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr_en,
  input  logic [OUTW-1:0] wr_data,
  input  logic            rd_en,
  output logic [OUTW-1:0] rd_data,
  output logic            full,
  output logic            empty
);

  localparam int unsigned PTR_BITS = $clog2(DEPTH);

  logic [OUTW-1:0]   mem [DEPTH];
  logic [PTR_BITS-1:0] wr_ptr;
  logic [PTR_BITS-1:0] rd_ptr;
  logic [PTR_BITS:0]   count;
  logic                do_wr;
  logic                do_rd;

  assign full  = (count == (PTR_BITS + 1)'(DEPTH));
  assign empty = (count == '0);
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  // Head is forced to zero when empty so the stream data is quiet after reset.
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + PTR_BITS'(1);
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + PTR_BITS'(1);
      end
      if (do_wr && !do_rd) begin
        count <= count + (PTR_BITS + 1)'(1);
      end else if (do_rd && !do_wr) begin
        count <= count - (PTR_BITS + 1)'(1);
      end
    end
  end

endmodule

// File: rtl/output_mems.sv
// Output matrix sequencer: counts accepted result words into a FIFO and
// streams them out on AXI-Stream with TLAST on the final word of the matrix.
module output_mems
  import conv_pkg::*;
#(
  parameter int unsigned OUTW  = 56,
  parameter int unsigned R     = 9,
  parameter int unsigned C     = 8,
  parameter int unsigned MAXK  = 4,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned K_BITS   = k_bits(MAXK),
  localparam int unsigned CNT_BITS = cnt_bits(R, C)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [K_BITS-1:0] K,
  input  logic [OUTW-1:0]   in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [OUTW-1:0]   AXIS_TDATA,
  output logic              AXIS_TVALID,
  input  logic              AXIS_TREADY,
  output logic              AXIS_TLAST,
  output logic              out_done
);

  state_t              state, state_nxt;
  logic [CNT_BITS-1:0] total, total_nxt;
  logic [CNT_BITS-1:0] in_cnt, in_cnt_nxt;
  logic [CNT_BITS-1:0] out_cnt, out_cnt_nxt;
  logic                done_nxt;
  logic                fifo_full;
  logic                fifo_empty;
  logic                push;
  logic                pop;
  logic                k_ok;
  logic [31:0]         k_ext;

  assign k_ext = 32'(K);
  assign k_ok  = (k_ext >= 32'd1) && (k_ext <= MAXK) && (k_ext <= R) && (k_ext <= C);

  assign in_ready    = (state == ACTIVE) && !fifo_full && (in_cnt < total);
  assign AXIS_TVALID = !fifo_empty;
  assign AXIS_TLAST  = AXIS_TVALID && (total != '0) && (out_cnt == total - CNT_BITS'(1));
  assign push        = in_valid && in_ready;
  assign pop         = AXIS_TVALID && AXIS_TREADY;

  output_fifo #(
    .OUTW  (OUTW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push),
    .wr_data (in_data),
    .rd_en   (pop),
    .rd_data (AXIS_TDATA),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    state_nxt   = state;
    total_nxt   = total;
    in_cnt_nxt  = in_cnt;
    out_cnt_nxt = out_cnt;
    done_nxt    = 1'b0;
    if (push) begin
      in_cnt_nxt = in_cnt + CNT_BITS'(1);
    end
    if (pop) begin
      out_cnt_nxt = out_cnt + CNT_BITS'(1);
    end
    case (state)
      IDLE: begin
        if (start && k_ok) begin
          state_nxt   = ACTIVE;
          total_nxt   = CNT_BITS'(out_total(R, C, k_ext));
          in_cnt_nxt  = '0;
          out_cnt_nxt = '0;
        end
      end
      ACTIVE: begin
        if (push && (in_cnt + CNT_BITS'(1) == total)) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN:   state_nxt = DRAIN;
      default: state_nxt = IDLE;
    endcase
    // The final transfer ends the matrix from any state, overriding ACTIVE->DRAIN.
    if (pop && AXIS_TLAST) begin
      state_nxt   = IDLE;
      in_cnt_nxt  = '0;
      out_cnt_nxt = '0;
      done_nxt    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      total    <= '0;
      in_cnt   <= '0;
      out_cnt  <= '0;
      out_done <= 1'b0;
    end else begin
      state    <= state_nxt;
      total    <= total_nxt;
      in_cnt   <= in_cnt_nxt;
      out_cnt  <= out_cnt_nxt;
      out_done <= done_nxt;
    end
  end

endmodule
